// File: rtl/i2cs.sv
`timescale 1ns/1ps
// I2C target: answers one 7-bit address and exposes a byte-wide register port
// with an auto-incrementing pointer. SCL is never stretched; SDA is open-drain.
module i2cs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_oe,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StIgnore, StAck, StPtr, StWdata, StRdata, StMack
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_h;
  logic        sda_s1, sda_s2, sda_h;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shift;
  logic [7:0]  ptr;
  logic [7:0]  rx_byte;
  logic [3:0]  bit_cnt;
  logic        rw;        // 1 = current transaction is a read
  logic        ptr_rcvd;  // pointer byte already taken in this write
  logic        ack_drv;   // ACK slot: 0 = waiting to drive, 1 = driving
  logic        rd_load;   // reg_rdata is valid this cycle

  assign i2c_scl_o  = 1'b0;
  assign i2c_scl_oe = 1'b0;
  assign i2c_sda_o  = 1'b0;
  assign reg_addr   = ptr;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & ~sda_s2 & sda_h;
  assign stop_det  = scl_s2 & scl_h & sda_s2 & ~sda_h;
  assign rx_byte   = {shift[6:0], sda_s2};

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= i2c_scl_i;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= i2c_sda_i;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // Protocol FSM with registered outputs, strobes and register pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      shift      <= 8'h00;
      ptr        <= 8'h00;
      bit_cnt    <= 4'd0;
      rw         <= 1'b0;
      ptr_rcvd   <= 1'b0;
      ack_drv    <= 1'b0;
      rd_load    <= 1'b0;
      i2c_sda_oe <= 1'b0;
      reg_wdata  <= 8'h00;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      busy       <= 1'b0;
      addressed  <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      reg_re  <= 1'b0;
      rd_load <= reg_re;
      if (rd_load) shift <= reg_rdata;
      // Write pointer advances the cycle after the strobe.
      if (reg_we) ptr <= ptr + 8'd1;

      if (start_det) begin
        state      <= StAddr;
        bit_cnt    <= 4'd0;
        ack_drv    <= 1'b0;
        i2c_sda_oe <= 1'b0;
        busy       <= 1'b1;
        addressed  <= 1'b0;
      end else if (stop_det) begin
        state      <= StIdle;
        i2c_sda_oe <= 1'b0;
        busy       <= 1'b0;
        addressed  <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StIgnore: ;

          StAddr: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (bit_cnt == 4'd7) begin
                // General call (address 0) is never claimed.
                if (shift[6:0] == SLAVE_ADDR && shift[6:0] != 7'd0) begin
                  addressed <= 1'b1;
                  rw        <= sda_s2;
                  ptr_rcvd  <= 1'b0;
                  ack_drv   <= 1'b0;
                  state     <= StAck;
                  if (sda_s2) reg_re <= 1'b1;
                end else begin
                  state <= StIgnore;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          StAck: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                i2c_sda_oe <= 1'b1;
                ack_drv    <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= 4'd0;
                if (rw) begin
                  i2c_sda_oe <= ~shift[7];
                  state      <= StRdata;
                end else begin
                  i2c_sda_oe <= 1'b0;
                  state      <= ptr_rcvd ? StWdata : StPtr;
                end
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (bit_cnt == 4'd7) begin
                ptr      <= rx_byte;
                ptr_rcvd <= 1'b1;
                state    <= StAck;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          StWdata: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (bit_cnt == 4'd7) begin
                reg_we    <= 1'b1;
                reg_wdata <= rx_byte;
                state     <= StAck;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          StRdata: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                i2c_sda_oe <= 1'b0;
                state      <= StMack;
              end else if (bit_cnt == 4'd0) begin
                // First bit of a byte fetched after a master ACK.
                i2c_sda_oe <= ~shift[7];
              end else begin
                shift      <= {shift[6:0], 1'b0};
                i2c_sda_oe <= ~shift[6];
              end
            end
          end

          StMack: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                ptr     <= ptr + 8'd1;
                reg_re  <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= StRdata;
              end else begin
                i2c_sda_oe <= 1'b0;
                state      <= StIgnore;
              end
            end
          end

          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2cs.sv
`timescale 1ns/1ps
// Bench for i2cs: bit-banged I2C master, register-bank model and a strobe
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_i2cs;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       scl_o, scl_oe, sda_o, sda_oe;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_we, reg_re, busy, addressed;
  logic [7:0] mem [256];

  int total = 0;
  int bad = 0;
  logic oe_seen = 1'b0;

  typedef struct packed {
    logic       is_re;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_m & ~sda_oe;

  i2cs #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_scl_i  (scl_m),
    .i2c_scl_o  (scl_o),
    .i2c_scl_oe (scl_oe),
    .i2c_sda_i  (sda_line),
    .i2c_sda_o  (sda_o),
    .i2c_sda_oe (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .addressed  (addressed)
  );

  // Register bank: read data valid the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) oe_seen = 1'b1;
      if (reg_we || reg_re) begin
        chk("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got we=%0d re=%0d addr=%0h want none",
                   reg_we, reg_re, reg_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", {31'd0, reg_re}, {31'd0, e.is_re});
          chk("strobe_addr", {24'd0, reg_addr}, {24'd0, e.addr});
          if (!e.is_re) chk("strobe_wdata", {24'd0, reg_wdata}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic push_we(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{is_re: 1'b0, addr: a, data: d});
  endtask

  task automatic push_re(input logic [7:0] a);
    exp_q.push_back('{is_re: 1'b1, addr: a, data: 8'h00});
  endtask

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start;  // from idle bus
    sda_m = 1'b1; scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic i2c_rstart;  // from SCL low
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b0; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic i2c_stop;  // from SCL low
    sda_m = 1'b0; wait_q;
    scl_m = 1'b1; wait_q;
    sda_m = 1'b1; wait_q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q;
    scl_m = 1'b1; wait_q; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_q;
    scl_m = 1'b1; wait_q;
    b = sda_line; wait_q;
    scl_m = 1'b0; wait_q;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] addr_a0;
    addr_a0 = 8'hA0;
    mem[8'h20] = 8'h3C;
    mem[8'h21] = 8'h96;
    mem[8'h00] = 8'hE7;

    // Reset values
    repeat (5) @(negedge clk);
    chk("reset_outputs", {7'd0, sda_oe, reg_we, reg_re, busy, addressed, reg_addr, reg_wdata},
        32'd0);
    chk("reset_consts", {29'd0, scl_o, scl_oe, sda_o}, 32'd0);
    rst = 1'b0;
    wait_q;

    // Write: pointer 0x10, data 0x5A, 0xC3
    push_we(8'h10, 8'h5A);
    push_we(8'h11, 8'hC3);
    i2c_start;
    chk("wr_busy_start", {31'd0, busy}, 32'd1);
    write_byte(8'hA0, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_addressed", {31'd0, addressed}, 32'd1);
    write_byte(8'h10, ack); chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack); chk("wr_d0_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hC3, ack); chk("wr_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop; wait_q;
    chk("wr_busy_stop", {31'd0, busy}, 32'd0);
    chk("wr_queue_empty", exp_q.size(), 32'd0);

    // Read: pointer 0x20, repeated START, two bytes (ACK then NACK)
    push_re(8'h20);
    push_re(8'h21);
    i2c_start;
    write_byte(8'hA0, ack); chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h20, ack); chk("rd_ptr_ack", {31'd0, ack}, 32'd0);
    i2c_rstart;
    write_byte(8'hA1, ack); chk("rd_addr1_ack", {31'd0, ack}, 32'd0);
    read_byte(d, 1'b0); chk("rd_byte0", {24'd0, d}, 32'h3C);
    read_byte(d, 1'b1); chk("rd_byte1", {24'd0, d}, 32'h96);
    chk("rd_sda_released", {31'd0, sda_oe}, 32'd0);
    i2c_stop; wait_q;
    chk("rd_queue_empty", exp_q.size(), 32'd0);

    // Address mismatch: never drive SDA, never strobe
    oe_seen = 1'b0;
    i2c_start;
    write_byte(8'hA2, ack); chk("mis_addr_nack", {31'd0, ack}, 32'd1);
    chk("mis_addressed", {31'd0, addressed}, 32'd0);
    write_byte(8'h33, ack); chk("mis_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop; wait_q;
    chk("mis_no_sda_oe", {31'd0, oe_seen}, 32'd0);

    // Pointer wraparound
    push_we(8'hFF, 8'h11);
    push_we(8'h00, 8'h22);
    i2c_start;
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); chk("wrap_d0_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h22, ack); chk("wrap_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop; wait_q;
    chk("wrap_queue_empty", exp_q.size(), 32'd0);

    // START after 4 bits of a data byte
    i2c_start;
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    i2c_rstart;
    chk("mid_sda_released", {31'd0, sda_oe}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_no_strobe", exp_q.size(), 32'd0);
    push_we(8'h41, 8'h77);
    write_byte(addr_a0, ack); chk("mid_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h41, ack);
    write_byte(8'h77, ack); chk("mid_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop; wait_q;
    chk("mid_queue_empty", exp_q.size(), 32'd0);

    // Reset while driving the address ACK
    i2c_start;
    for (int i = 7; i >= 0; i--) send_bit(addr_a0[i]);
    chk("rst_ack_driven", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_ptr", {24'd0, reg_addr}, 32'd0);
    chk("rst_busy", {30'd0, busy, addressed}, 32'd0);
    sda_m = 1'b1;
    scl_m = 1'b1; wait_q; wait_q;
    scl_m = 1'b0; wait_q;
    chk("rst_idle_no_drive", {31'd0, sda_oe}, 32'd0);
    i2c_stop; wait_q;

    // Read without a pointer write uses the reset pointer
    push_re(8'h00);
    i2c_start;
    write_byte(8'hA1, ack); chk("post_rst_ack", {31'd0, ack}, 32'd0);
    read_byte(d, 1'b1); chk("post_rst_data", {24'd0, d}, 32'hE7);
    i2c_stop; wait_q;
    chk("post_rst_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
